// File: rtl/alu_operand_stage_if.sv
// Bundle between decode/MEM/ALU and the ID/EX operand stage.
// The master drives decode and forwarding inputs; the slave is the stage itself.
interface alu_operand_stage_if;
  logic        dec_valid;
  logic [3:0]  dec_alu_op;
  logic [4:0]  dec_rs_addr;
  logic [4:0]  dec_rt_addr;
  logic [31:0] dec_rs_data;
  logic [31:0] dec_rt_data;
  logic        dec_uses_rs;
  logic        dec_uses_rt;
  logic        dec_use_imm;
  logic [31:0] dec_imm;
  logic        dec_use_shamt;
  logic [4:0]  dec_shamt;
  logic        dec_wr_en;
  logic [4:0]  dec_wr_addr;
  logic        dec_is_load;
  logic [31:0] alu_result;
  logic        mem_wr_en;
  logic [4:0]  mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        stall;
  logic        flush;
  logic [3:0]  alu_op;
  logic [31:0] alu_op_x;
  logic [31:0] alu_op_y;
  logic        ex_valid;
  logic        ex_wr_en;
  logic [4:0]  ex_wr_addr;
  logic        ex_is_load;
  logic        hazard_stall;

  modport master (
    output dec_valid, dec_alu_op, dec_rs_addr, dec_rt_addr, dec_rs_data, dec_rt_data,
           dec_uses_rs, dec_uses_rt, dec_use_imm, dec_imm, dec_use_shamt, dec_shamt,
           dec_wr_en, dec_wr_addr, dec_is_load, alu_result, mem_wr_en, mem_wr_addr,
           mem_wr_data, stall, flush,
    input  alu_op, alu_op_x, alu_op_y, ex_valid, ex_wr_en, ex_wr_addr, ex_is_load,
           hazard_stall
  );

  modport slave (
    input  dec_valid, dec_alu_op, dec_rs_addr, dec_rt_addr, dec_rs_data, dec_rt_data,
           dec_uses_rs, dec_uses_rt, dec_use_imm, dec_imm, dec_use_shamt, dec_shamt,
           dec_wr_en, dec_wr_addr, dec_is_load, alu_result, mem_wr_en, mem_wr_addr,
           mem_wr_data, stall, flush,
    output alu_op, alu_op_x, alu_op_y, ex_valid, ex_wr_en, ex_wr_addr, ex_is_load,
           hazard_stall
  );
endinterface

// File: rtl/alu_operand_stage.sv
// ID/EX register feeding the integer ALU: operand forwarding, load-use bubble
// insertion, downstream stall hold and flush squash.
module alu_operand_stage #(
  parameter logic [3:0] NOP_OP = 4'd0
) (
  input logic clk,
  input logic rst,
  alu_operand_stage_if.slave bus
);

  logic        ex_valid_reg, ex_valid_next;
  logic        ex_wr_en_reg, ex_wr_en_next;
  logic [4:0]  ex_wr_addr_reg, ex_wr_addr_next;
  logic        ex_is_load_reg, ex_is_load_next;
  logic [3:0]  alu_op_reg, alu_op_next;
  logic [31:0] op_x_reg, op_x_next;
  logic [31:0] op_y_reg, op_y_next;

  logic [1:0][4:0]  src_addr;
  logic [1:0][31:0] src_rf;
  logic [1:0][31:0] src_fwd;
  logic [1:0]       src_uses;
  logic [1:0]       src_hazard;

  logic        hazard;
  logic        load_bubble;
  logic        ex_alu_wr;

  assign src_addr[0] = bus.dec_rs_addr;
  assign src_addr[1] = bus.dec_rt_addr;
  assign src_rf[0]   = bus.dec_rs_data;
  assign src_rf[1]   = bus.dec_rt_data;
  // rt only matters for the hazard when Y really comes from the register file
  assign src_uses[0] = bus.dec_uses_rs;
  assign src_uses[1] = bus.dec_uses_rt & ~bus.dec_use_imm;

  assign ex_alu_wr   = ex_valid_reg & ex_wr_en_reg & ~ex_is_load_reg;
  assign load_bubble = ex_valid_reg & ex_is_load_reg & ex_wr_en_reg & (ex_wr_addr_reg != 5'd0);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      logic nonzero;
      logic ex_hit;
      logic mem_hit;

      assign nonzero = (src_addr[gi] != 5'd0);
      assign ex_hit  = nonzero & ex_alu_wr & (ex_wr_addr_reg == src_addr[gi]);
      assign mem_hit = nonzero & bus.mem_wr_en & (bus.mem_wr_addr == src_addr[gi]);

      assign src_fwd[gi] = ex_hit  ? bus.alu_result :
                           mem_hit ? bus.mem_wr_data :
                                     src_rf[gi];

      assign src_hazard[gi] = src_uses[gi] & (src_addr[gi] == ex_wr_addr_reg);
    end
  endgenerate

  assign hazard = bus.dec_valid & load_bubble & (|src_hazard);

  always_comb begin
    ex_valid_next   = ex_valid_reg;
    ex_wr_en_next   = ex_wr_en_reg;
    ex_wr_addr_next = ex_wr_addr_reg;
    ex_is_load_next = ex_is_load_reg;
    alu_op_next     = alu_op_reg;
    op_x_next       = op_x_reg;
    op_y_next       = op_y_reg;
    // flush beats stall; a stall with no flush holds everything as-is
    if (bus.flush || (!bus.stall && (hazard || !bus.dec_valid))) begin
      ex_valid_next   = 1'b0;
      ex_wr_en_next   = 1'b0;
      ex_wr_addr_next = 5'd0;
      ex_is_load_next = 1'b0;
      alu_op_next     = NOP_OP;
      op_x_next       = 32'd0;
      op_y_next       = 32'd0;
    end else if (!bus.stall) begin
      ex_valid_next   = 1'b1;
      ex_wr_en_next   = bus.dec_wr_en;
      ex_wr_addr_next = bus.dec_wr_addr;
      ex_is_load_next = bus.dec_is_load;
      alu_op_next     = bus.dec_alu_op;
      op_x_next       = bus.dec_use_shamt ? {27'd0, bus.dec_shamt} : src_fwd[0];
      op_y_next       = bus.dec_use_imm ? bus.dec_imm : src_fwd[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_reg   <= 1'b0;
      ex_wr_en_reg   <= 1'b0;
      ex_wr_addr_reg <= 5'd0;
      ex_is_load_reg <= 1'b0;
      alu_op_reg     <= NOP_OP;
      op_x_reg       <= 32'd0;
      op_y_reg       <= 32'd0;
    end else begin
      ex_valid_reg   <= ex_valid_next;
      ex_wr_en_reg   <= ex_wr_en_next;
      ex_wr_addr_reg <= ex_wr_addr_next;
      ex_is_load_reg <= ex_is_load_next;
      alu_op_reg     <= alu_op_next;
      op_x_reg       <= op_x_next;
      op_y_reg       <= op_y_next;
    end
  end

  assign bus.alu_op       = alu_op_reg;
  assign bus.alu_op_x     = op_x_reg;
  assign bus.alu_op_y     = op_y_reg;
  assign bus.ex_valid     = ex_valid_reg;
  assign bus.ex_wr_en     = ex_wr_en_reg;
  assign bus.ex_wr_addr   = ex_wr_addr_reg;
  assign bus.ex_is_load   = ex_is_load_reg;
  assign bus.hazard_stall = hazard;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed scenarios with literal expectations
// followed by randomized traffic checked every cycle against a behavioural model.
module tb_alu_operand_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_operand_stage_if bus ();

  alu_operand_stage #(.NOP_OP(4'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // model of the instruction currently held in EX
  logic        m_valid, m_wr, m_load;
  logic [4:0]  m_dst;
  logic [3:0]  m_op;
  logic [31:0] m_x, m_y;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_bubble();
    m_valid = 0; m_wr = 0; m_load = 0; m_dst = 0; m_op = 0; m_x = 0; m_y = 0;
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] rf);
    if (a == 0) return rf;
    if (m_valid && m_wr && !m_load && m_dst == a) return bus.alu_result;
    if (bus.mem_wr_en && bus.mem_wr_addr == a) return bus.mem_wr_data;
    return rf;
  endfunction

  function automatic logic m_hazard();
    logic rs_dep, rt_dep;
    rs_dep = bus.dec_uses_rs && bus.dec_rs_addr == m_dst;
    rt_dep = bus.dec_uses_rt && !bus.dec_use_imm && bus.dec_rt_addr == m_dst;
    return bus.dec_valid && m_valid && m_load && m_wr && m_dst != 0 && (rs_dep || rt_dep);
  endfunction

  task automatic compare_outputs();
    chk("alu_op", {28'd0, bus.alu_op}, {28'd0, m_op});
    chk("alu_op_x", bus.alu_op_x, m_x);
    chk("alu_op_y", bus.alu_op_y, m_y);
    chk("ex_valid", {31'd0, bus.ex_valid}, {31'd0, m_valid});
    chk("ex_wr_en", {31'd0, bus.ex_wr_en}, {31'd0, m_wr});
    chk("ex_wr_addr", {27'd0, bus.ex_wr_addr}, {27'd0, m_dst});
    chk("ex_is_load", {31'd0, bus.ex_is_load}, {31'd0, m_load});
  endtask

  // inputs are already driven; check hazard, predict, clock, check registers
  task automatic step();
    logic hz;
    #1;
    hz = m_hazard();
    chk("hazard_stall", {31'd0, bus.hazard_stall}, {31'd0, hz});
    if (bus.flush) model_bubble();
    else if (bus.stall) ;
    else if (hz || !bus.dec_valid) model_bubble();
    else begin
      m_x     = bus.dec_use_shamt ? {27'd0, bus.dec_shamt} : fwd(bus.dec_rs_addr, bus.dec_rs_data);
      m_y     = bus.dec_use_imm ? bus.dec_imm : fwd(bus.dec_rt_addr, bus.dec_rt_data);
      m_valid = 1; m_wr = bus.dec_wr_en; m_load = bus.dec_is_load;
      m_dst   = bus.dec_wr_addr; m_op = bus.dec_alu_op;
    end
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic clear_inputs();
    bus.dec_valid = 0; bus.dec_alu_op = 0; bus.dec_rs_addr = 0; bus.dec_rt_addr = 0;
    bus.dec_rs_data = 0; bus.dec_rt_data = 0; bus.dec_uses_rs = 0; bus.dec_uses_rt = 0;
    bus.dec_use_imm = 0; bus.dec_imm = 0; bus.dec_use_shamt = 0; bus.dec_shamt = 0;
    bus.dec_wr_en = 0; bus.dec_wr_addr = 0; bus.dec_is_load = 0; bus.alu_result = 0;
    bus.mem_wr_en = 0; bus.mem_wr_addr = 0; bus.mem_wr_data = 0; bus.stall = 0; bus.flush = 0;
  endtask

  task automatic instr(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic wr, input logic ld);
    bus.dec_valid = 1; bus.dec_alu_op = op;
    bus.dec_rs_addr = rs; bus.dec_rt_addr = rt; bus.dec_uses_rs = 1; bus.dec_uses_rt = 1;
    bus.dec_wr_addr = rd; bus.dec_wr_en = wr; bus.dec_is_load = ld;
  endtask

  task automatic rand_inputs();
    bus.dec_valid     = ($urandom_range(3) != 0);
    bus.dec_alu_op    = 4'($urandom_range(14));
    bus.dec_rs_addr   = 5'($urandom_range(7));
    bus.dec_rt_addr   = 5'($urandom_range(7));
    bus.dec_rs_data   = $urandom;
    bus.dec_rt_data   = $urandom;
    bus.dec_uses_rs   = 1'($urandom);
    bus.dec_uses_rt   = 1'($urandom);
    bus.dec_use_imm   = ($urandom_range(3) == 0);
    bus.dec_imm       = $urandom;
    bus.dec_use_shamt = ($urandom_range(5) == 0);
    bus.dec_shamt     = 5'($urandom);
    bus.dec_wr_en     = ($urandom_range(3) != 0);
    bus.dec_wr_addr   = 5'($urandom_range(7));
    bus.dec_is_load   = ($urandom_range(3) == 0);
    bus.alu_result    = $urandom;
    bus.mem_wr_en     = 1'($urandom);
    bus.mem_wr_addr   = 5'($urandom_range(7));
    bus.mem_wr_data   = $urandom;
    bus.stall         = ($urandom_range(7) == 0);
    bus.flush         = ($urandom_range(9) == 0);
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    model_bubble();
    compare_outputs();
    chk("rst_hazard", {31'd0, bus.hazard_stall}, {31'd0, m_hazard()});
    rst = 0;
  endtask

  logic [31:0] save_x, save_y;
  logic [3:0]  save_op;

  initial begin
    clear_inputs();
    rst = 1;
    model_bubble();
    @(posedge clk); #1;
    chk("reset_alu_op", {28'd0, bus.alu_op}, 32'd0);
    chk("reset_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("reset_op_x", bus.alu_op_x, 32'd0);
    chk("reset_hazard", {31'd0, bus.hazard_stall}, 32'd0);
    compare_outputs();
    rst = 0;

    // EX forward
    instr(4'd0, 5'd1, 5'd2, 5'd3, 1, 0); step();
    instr(4'd5, 5'd3, 5'd2, 5'd6, 1, 0); bus.dec_rs_data = 0; bus.alu_result = 32'h15; step();
    chk("exfwd_x", bus.alu_op_x, 32'h15);
    chk("exfwd_op", {28'd0, bus.alu_op}, 32'd5);

    // EX beats MEM; r0 never forwards
    instr(4'd0, 5'd1, 5'd2, 5'd4, 1, 0); step();
    instr(4'd0, 5'd4, 5'd1, 5'd7, 0, 0); bus.dec_rs_data = 32'h33;
    bus.alu_result = 7; bus.mem_wr_en = 1; bus.mem_wr_addr = 4; bus.mem_wr_data = 9; step();
    chk("prio_ex_over_mem", bus.alu_op_x, 32'd7);
    instr(4'd0, 5'd1, 5'd2, 5'd0, 1, 0); bus.mem_wr_en = 0; step();
    instr(4'd0, 5'd0, 5'd1, 5'd7, 0, 0); bus.dec_rs_data = 0;
    bus.alu_result = 7; bus.mem_wr_en = 1; bus.mem_wr_addr = 0; bus.mem_wr_data = 9; step();
    chk("prio_r0", bus.alu_op_x, 32'd0);

    // load-use: one bubble, retry picks up MEM data
    bus.mem_wr_en = 0;
    instr(4'd0, 5'd1, 5'd2, 5'd5, 1, 1); step();
    instr(4'd0, 5'd5, 5'd9, 5'd8, 0, 0); bus.dec_uses_rt = 0; bus.dec_rs_data = 0;
    #1;
    chk("loaduse_hazard", {31'd0, bus.hazard_stall}, 32'd1);
    step();
    chk("loaduse_bubble", {31'd0, bus.ex_valid}, 32'd0);
    bus.mem_wr_en = 1; bus.mem_wr_addr = 5; bus.mem_wr_data = 32'hDEAD; step();
    chk("loaduse_retry_x", bus.alu_op_x, 32'hDEAD);
    chk("loaduse_retry_valid", {31'd0, bus.ex_valid}, 32'd1);

    // shift and immediate
    bus.mem_wr_en = 0;
    instr(4'd10, 5'd1, 5'd9, 5'd8, 1, 0); bus.dec_use_shamt = 1; bus.dec_shamt = 4;
    bus.dec_rt_data = 1; step();
    chk("sll_op", {28'd0, bus.alu_op}, 32'd10);
    chk("sll_x", bus.alu_op_x, 32'd4);
    chk("sll_y", bus.alu_op_y, 32'd1);
    bus.dec_use_shamt = 0; bus.dec_use_imm = 1; bus.dec_imm = 32'hFFFF_FFFF; step();
    chk("addiu_y", bus.alu_op_y, 32'hFFFF_FFFF);

    // stall holds for three cycles, then stall+flush squashes
    save_op = bus.alu_op; save_x = bus.alu_op_x; save_y = bus.alu_op_y;
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      instr(4'($urandom_range(14)), 5'd3, 5'd4, 5'd6, 1, 0); bus.dec_rs_data = $urandom;
      step();
    end
    chk("stall_op", {28'd0, bus.alu_op}, {28'd0, save_op});
    chk("stall_x", bus.alu_op_x, save_x);
    chk("stall_y", bus.alu_op_y, save_y);
    bus.flush = 1; step();
    chk("flush_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("flush_wr_en", {31'd0, bus.ex_wr_en}, 32'd0);

    // reset in the middle of traffic
    clear_inputs();
    instr(4'd3, 5'd1, 5'd2, 5'd5, 1, 1); step();
    rst = 1; #1;
    chk("midrst_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("midrst_load", {31'd0, bus.ex_is_load}, 32'd0);
    chk("midrst_op", {28'd0, bus.alu_op}, 32'd0);
    model_bubble();
    rst = 0;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(199) == 0) do_reset();
      rand_inputs();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
